// File: rtl/multi_cycle_n_bit_adder.sv
`default_nettype none
// ============================================================================
//  Module   : multi_cycle_n_bit_adder
//  Purpose  : N-bit add/subtract computed W bits per clock, LSB chunk first,
//             with a start/busy/done handshake, carry-out and signed overflow.
//  Revision : 1.0  initial release
// ============================================================================
module multi_cycle_n_bit_adder #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    localparam int c_CHUNKS = N / W;
    localparam int c_KW     = (c_CHUNKS > 1) ? $clog2(c_CHUNKS) : 1;
    localparam logic [c_KW-1:0] c_LAST = c_KW'(c_CHUNKS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [N-1:0]    r_opa;
    logic [N-1:0]    r_opb;
    logic [N-1:0]    r_res;
    logic            r_carry;
    logic [c_KW-1:0] r_k;
    logic            r_sign_a;
    logic            r_sign_b;
    logic [N-1:0]    r_s;
    logic            r_cout;
    logic            r_ovf;

    logic            w_accept;
    logic            w_last;
    logic [W:0]      w_sum;
    logic [N-1:0]    w_opa_next;
    logic [N-1:0]    w_opb_next;
    logic [N-1:0]    w_res_next;
    logic            w_ovf;

    // Operands shift right one chunk per cycle so the live chunk always sits
    // at bit 0; result chunks enter at the top and land in place after C shifts.
    assign w_sum = {1'b0, r_opa[W-1:0]} + {1'b0, r_opb[W-1:0]} + {{W{1'b0}}, r_carry};

    generate
        if (W == N) begin : g_single
            assign w_opa_next = '0;
            assign w_opb_next = '0;
            assign w_res_next = w_sum[W-1:0];
        end else begin : g_multi
            assign w_opa_next = {{W{1'b0}}, r_opa[N-1:W]};
            assign w_opb_next = {{W{1'b0}}, r_opb[N-1:W]};
            assign w_res_next = {w_sum[W-1:0], r_res[N-1:W]};
        end
    endgenerate

    assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_last   = (r_k == c_LAST);
    // Operand signs are kept aside since the shifting operands lose their MSBs.
    assign w_ovf    = (r_sign_a == r_sign_b) && (w_res_next[N-1] != r_sign_a);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_opa    <= '0;
            r_opb    <= '0;
            r_res    <= '0;
            r_carry  <= 1'b0;
            r_k      <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_s      <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    if (w_accept) begin
                        r_opa    <= a;
                        r_opb    <= sub ? ~b : b;
                        r_sign_a <= a[N-1];
                        r_sign_b <= sub ? ~b[N-1] : b[N-1];
                        r_carry  <= sub | cin;
                        r_k      <= '0;
                        r_res    <= '0;
                        r_state  <= c_RUN;
                    end else begin
                        r_state  <= c_IDLE;
                    end
                end
                c_RUN: begin
                    r_opa   <= w_opa_next;
                    r_opb   <= w_opb_next;
                    r_res   <= w_res_next;
                    r_carry <= w_sum[W];
                    r_k     <= r_k + c_KW'(1);
                    if (w_last) begin
                        r_s     <= w_res_next;
                        r_cout  <= w_sum[W];
                        r_ovf   <= w_ovf;
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == c_RUN);
    assign done = (r_state == c_DONE);
    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire
